// File: rtl/acumulador_ula.sv
// Sequencing accumulator placed in front of an external 8-bit ALU: it accepts one
// command at a time, drives the ALU operands from registers and folds the result back into acc.
module acumulador_ula #(
    parameter int NBITS = 8,
    parameter int CBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic [NBITS-1:0] ula_a,
    output logic [NBITS-1:0] ula_b,
    output logic [1:0]       ula_f,
    input  logic [NBITS-1:0] ula_saida,
    input  logic             ula_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] acc,
    output logic             flag_ult,
    output logic             flag_acum,
    output logic [CBITS-1:0] cont
);

    typedef enum logic [1:0] {OCIOSO, EXECUTA, RESULTADO} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    state_t           state;
    logic [NBITS-1:0] b_reg;
    logic [2:0]       op_reg;

    // The ALU operands come straight from registers, so they are stable for the whole EXECUTA cycle.
    assign ula_a = acc;
    assign ula_b = b_reg;
    assign ula_f = op_reg[1:0];

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCIOSO;
            b_reg     <= '0;
            op_reg    <= '0;
            acc       <= '0;
            flag_ult  <= 1'b0;
            flag_acum <= 1'b0;
            cont      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (in_valid) begin
                        b_reg    <= in_b;
                        op_reg   <= in_op;
                        in_ready <= 1'b0;
                        state    <= EXECUTA;
                    end
                end
                EXECUTA: begin
                    cont      <= cont + 1'b1;
                    out_valid <= 1'b1;
                    state     <= RESULTADO;
                    if (!op_reg[2]) begin
                        acc       <= ula_saida;
                        flag_ult  <= ula_flag;
                        flag_acum <= flag_acum | ula_flag;
                    end else if (op_reg == OP_LOAD) begin
                        acc      <= b_reg;
                        flag_ult <= 1'b0;
                    end else if (op_reg == OP_CLEAR) begin
                        acc       <= '0;
                        flag_ult  <= 1'b0;
                        flag_acum <= 1'b0;
                    end else begin
                        flag_ult <= 1'b0;
                    end
                end
                RESULTADO: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= OCIOSO;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_ula.sv
// Directed bench for acumulador_ula: a behavioural ALU closes the loop, and a scoreboard
// queue holds the expected results of every accepted command until the DUT presents them.
module tb_acumulador_ula;

    typedef struct {
        logic [7:0]  acc;
        logic        fu;
        logic        fa;
        logic [15:0] cont;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [7:0]  in_b = '0, ula_a, ula_b, ula_saida, acc;
    logic [2:0]  in_op = '0;
    logic [1:0]  ula_f;
    logic        ula_flag, flag_ult, flag_acum;
    logic [15:0] cont;

    logic        in_valid2 = 1'b0, in_ready2, out_valid2;
    logic [7:0]  ula_a2, ula_b2, ula_saida2, acc2;
    logic [1:0]  ula_f2;
    logic        ula_flag2, flag_ult2, flag_acum2;
    logic [1:0]  cont2;

    int checks = 0;
    int failures = 0;

    exp_t sb[$];
    int   sb2[$];

    logic [7:0]  m_acc;
    logic        m_fu, m_fa;
    logic [15:0] m_cont;
    logic [1:0]  m2_cont;

    always #5 clk = ~clk;

    acumulador_ula #(.NBITS(8), .CBITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_b(in_b), .in_op(in_op), .ula_a(ula_a), .ula_b(ula_b), .ula_f(ula_f),
        .ula_saida(ula_saida), .ula_flag(ula_flag), .out_valid(out_valid),
        .out_ready(out_ready), .acc(acc), .flag_ult(flag_ult), .flag_acum(flag_acum),
        .cont(cont)
    );

    acumulador_ula #(.NBITS(8), .CBITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_b(8'h00), .in_op(3'b110), .ula_a(ula_a2), .ula_b(ula_b2), .ula_f(ula_f2),
        .ula_saida(ula_saida2), .ula_flag(ula_flag2), .out_valid(out_valid2),
        .out_ready(1'b1), .acc(acc2), .flag_ult(flag_ult2), .flag_acum(flag_acum2),
        .cont(cont2)
    );

    function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        logic [7:0] r;
        logic       v;
        case (f)
            2'b00: begin r = a & b; v = 1'b0; end
            2'b01: begin r = a | b; v = 1'b0; end
            2'b10: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
            default: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
        endcase
        return {v, r};
    endfunction

    always_comb {ula_flag, ula_saida} = alu(ula_a, ula_b, ula_f);
    always_comb {ula_flag2, ula_saida2} = alu(ula_a2, ula_b2, ula_f2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_fu = 1'b0; m_fa = 1'b0; m_cont = '0;
        sb.delete();
    endtask

    // Expected effect of a command, pushed when the DUT accepts it.
    task automatic model_apply(input logic [7:0] b, input logic [2:0] op);
        logic [8:0] r;
        exp_t       e;
        if (!op[2]) begin
            r = alu(m_acc, b, op[1:0]);
            m_acc = r[7:0]; m_fu = r[8]; m_fa = m_fa | r[8];
        end else if (op == 3'b100) begin
            m_acc = b; m_fu = 1'b0;
        end else if (op == 3'b101) begin
            m_acc = '0; m_fu = 1'b0; m_fa = 1'b0;
        end else begin
            m_fu = 1'b0;
        end
        m_cont = m_cont + 16'd1;
        e.acc = m_acc; e.fu = m_fu; e.fa = m_fa; e.cont = m_cont;
        sb.push_back(e);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_acc"}, acc, e.acc);
        check({tag, "_flag_ult"}, flag_ult, e.fu);
        check({tag, "_flag_acum"}, flag_acum, e.fa);
        check({tag, "_cont"}, cont, e.cont);
    endtask

    // Full command with out_ready high: acceptance, EXECUTA at k+1, result at k+2, idle again at k+3.
    task automatic run_cmd(input string tag, input logic [7:0] b, input logic [2:0] op);
        int         n;
        logic [7:0] prev_acc;
        @(negedge clk);
        in_b = b; in_op = op; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        prev_acc = m_acc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_apply(b, op);
        @(negedge clk);
        check({tag, "_exec_out_valid"}, out_valid, 1'b0);
        check({tag, "_exec_in_ready"}, in_ready, 1'b0);
        check({tag, "_ula_a"}, ula_a, prev_acc);
        check({tag, "_ula_b"}, ula_b, b);
        check({tag, "_ula_f"}, ula_f, op[1:0]);
        @(negedge clk);
        check({tag, "_res_out_valid"}, out_valid, 1'b1);
        check({tag, "_res_in_ready"}, in_ready, 1'b0);
        compare_result(tag);
        @(negedge clk);
        check({tag, "_idle_in_ready"}, in_ready, 1'b1);
        check({tag, "_idle_out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        m2_cont = '0;

        repeat (2) @(negedge clk);
        check("rst_acc", acc, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_cont", cont, 16'd0);
        rst_n = 1'b1;

        // Reset dropped asynchronously in the middle of an EXECUTA cycle.
        run_cmd("pre_load", 8'd100, 3'b100);
        @(negedge clk);
        in_b = 8'd50; in_op = 3'b010; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_acc", acc, 8'h00);
        check("async_rst_cont", cont, 16'd0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_ula_a", ula_a, 8'h00);
        check("async_rst_ula_b", ula_b, 8'h00);
        check("async_rst_ula_f", ula_f, 2'b00);
        check("async_rst_flag_ult", flag_ult, 1'b0);
        check("async_rst_flag_acum", flag_acum, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_cont", cont, 16'd0);
        check("post_rst_out_valid", out_valid, 1'b0);

        run_cmd("load100", 8'd100, 3'b100);
        run_cmd("add50", 8'd50, 3'b010);
        check("add50_wrap_value", acc, 8'h96);

        run_cmd("load_m128", 8'h80, 3'b100);
        run_cmd("sub1", 8'd1, 3'b011);
        run_cmd("and0f", 8'h0F, 3'b000);

        run_cmd("clear", 8'hAA, 3'b101);
        run_cmd("or55", 8'h55, 3'b001);
        run_cmd("nop", 8'hFF, 3'b111);
        run_cmd("add_neg", 8'h90, 3'b010);
        run_cmd("sub_under", 8'h7F, 3'b011);

        // Backpressure: result held while a second command waits on in_valid.
        out_ready = 1'b0;
        @(negedge clk);
        in_b = 8'h11; in_op = 3'b100; in_valid = 1'b1;
        @(posedge clk);
        #1 model_apply(8'h11, 3'b100);
        in_b = 8'h22; in_op = 3'b010;
        @(negedge clk);
        @(negedge clk);
        compare_result("bp_first");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_out_valid", out_valid, 1'b1);
            check("bp_hold_in_ready", in_ready, 1'b0);
            check("bp_hold_acc", acc, 8'h11);
            check("bp_hold_ula_b", ula_b, 8'h11);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_apply(8'h22, 3'b010);
        @(negedge clk);
        check("bp_second_exec_ula_b", ula_b, 8'h22);
        check("bp_second_exec_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check("bp_second_out_valid", out_valid, 1'b1);
        compare_result("bp_second");

        // Counter wrap on the CBITS=2 instance with NOP commands.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            @(posedge clk);
            #1 in_valid2 = 1'b0;
            m2_cont = m2_cont + 2'd1;
            sb2.push_back(int'(m2_cont));
            @(negedge clk);
            @(negedge clk);
            check("wrap_out_valid", out_valid2, 1'b1);
            if (sb2.size() != 0) check("wrap_cont", cont2, sb2.pop_front());
            check("wrap_acc", acc2, 8'h00);
            check("wrap_flag_ult", flag_ult2, 1'b0);
        end

        check("sb_drained", sb.size() + sb2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
